// File: rtl/piso_stream.sv
// Parallel-in serial-out shifter with a one-word holding buffer.
// Streams DW-bit words MSB- or LSB-first, back to back, with framing pulses.
module piso_stream #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          msb_first,
  output logic          ser_out,
  output logic          ser_valid,
  output logic          frame_start,
  output logic          done,
  output logic          busy
);

  localparam int CW = $clog2(DW);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] sh, sh_n;
  logic [DW-1:0] hold, hold_n;
  logic          sh_msb, sh_msb_n;
  logic          hold_msb, hold_msb_n;
  logic          hold_full, hold_full_n;
  logic          acc, last, free;
  logic          out_n, vld_n, fs_n, done_n, busy_n;

  assign in_ready = !hold_full && !rst;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sh_n        = sh;
    sh_msb_n    = sh_msb;
    hold_n      = hold;
    hold_msb_n  = hold_msb;
    hold_full_n = hold_full;
    acc  = in_valid && in_ready;
    last = (state == SHIFT) && (cnt == CW'(DW - 1));
    free = (state == IDLE) || (last && !hold_full);

    if (state == SHIFT) begin
      sh_n  = sh_msb ? (sh << 1) : (sh >> 1);
      cnt_n = cnt + CW'(1);
    end

    if (last) begin
      cnt_n = '0;
      if (hold_full) begin
        sh_n        = hold;
        sh_msb_n    = hold_msb;
        hold_full_n = 1'b0;
      end else begin
        state_n = IDLE;
      end
    end

    // a word accepted on the last bit follows with no gap
    if (acc) begin
      if (free) begin
        sh_n     = in_data;
        sh_msb_n = msb_first;
        state_n  = SHIFT;
        cnt_n    = '0;
      end else begin
        hold_n      = in_data;
        hold_msb_n  = msb_first;
        hold_full_n = 1'b1;
      end
    end

    vld_n  = (state_n == SHIFT);
    out_n  = vld_n && (sh_msb_n ? sh_n[DW-1] : sh_n[0]);
    fs_n   = vld_n && (cnt_n == '0);
    done_n = vld_n && (cnt_n == CW'(DW - 1));
    busy_n = vld_n || hold_full_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      sh_msb      <= 1'b0;
      hold        <= '0;
      hold_msb    <= 1'b0;
      hold_full   <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sh          <= sh_n;
      sh_msb      <= sh_msb_n;
      hold        <= hold_n;
      hold_msb    <= hold_msb_n;
      hold_full   <= hold_full_n;
      ser_out     <= out_n;
      ser_valid   <= vld_n;
      frame_start <= fs_n;
      done        <= done_n;
      busy        <= busy_n;
    end
  end

endmodule
